// File: rtl/kmul_stream_shell.sv
// kmul_stream_shell
// Handshake shell around a combinational Karatsuba multiplier (ports u, v, r).
// Operand pairs enter a 2-entry FIFO and are popped onto registered multiplier
// operands. Those operands are held for SETTLE cycles (multicycle path), then
// the 2N-bit product is captured into a valid/ready output register.
// Optional feature: define KMUL_SHELL_CHECK_EN to build a behavioural product
// comparator that raises a sticky err on any capture mismatch.
module kmul_stream_shell #(
    parameter int N      = 16,
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic [N-1:0]   mul_u,
    output logic [N-1:0]   mul_v,
    input  logic [2*N-1:0] mul_r,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_r,
    output logic           busy,
    output logic           err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_OUT
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [N-1:0]   mul_u_q, mul_u_d;
    logic [N-1:0]   mul_v_q, mul_v_d;
    logic [2*N-1:0] out_r_q, out_r_d;
    logic           out_valid_q, out_valid_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic           wr_ptr_q, wr_ptr_d;
    logic [1:0]     count_q, count_d;
    logic [N-1:0]   mem_a_q [2];
    logic [N-1:0]   mem_b_q [2];

    logic full, empty, push, pop, capture;

    // FIFO occupancy flags and push qualification; a same-cycle pop never raises in_ready.
    always_comb begin
        full     = (count_q == 2'd2);
        empty    = (count_q == 2'd0);
        in_ready = !full;
        push     = in_valid && !full;
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    // FIFO storage write on push.
    // NOTE: the storage array carries no reset; occupancy lives in count_q, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_a;
            mem_b_q[wr_ptr_q] <= in_b;
        end
    end

    // Sequencer: pop onto the multiplier, count out the settle window, present the product.
    // NOTE: every signal written here is given a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_u_d     = mul_u_q;
        mul_v_d     = mul_v_q;
        out_r_d     = out_r_q;
        out_valid_d = out_valid_q;
        pop         = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    capture     = 1'b1;
                    out_r_d     = mul_r;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    if (!empty) begin
                        pop = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A pop always loads fresh operands and restarts the settle window.
        if (pop) begin
            mul_u_d = mem_a_q[rd_ptr_q];
            mul_v_d = mem_b_q[rd_ptr_q];
            cnt_d   = 4'(SETTLE);
            state_d = S_SETTLE;
        end
    end

    // State, datapath and FIFO control registers with asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mul_u_q     <= '0;
            mul_v_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_u_q     <= mul_u_d;
            mul_v_q     <= mul_v_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    assign mul_u     = mul_u_q;
    assign mul_v     = mul_v_q;
    assign out_r     = out_r_q;
    assign out_valid = out_valid_q;
    assign busy      = !empty || (state_q != S_IDLE);

`ifdef KMUL_SHELL_CHECK_EN
    logic [2*N-1:0] ref_prod;
    logic           err_q, err_d;

    // Behavioural reference product and sticky mismatch flag, evaluated on the capture edge.
    always_comb begin
        ref_prod = (2*N)'(mul_u_q) * (2*N)'(mul_v_q);
        err_d    = err_q | (capture && (mul_r != ref_prod));
    end

    // Sticky error register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
